// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and one pending slot.
// Optional IF_ALIGN_CHK_EN: misaligned branch targets raise if_misalign_o and halt fetch.
module if_fetch #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
`ifdef IF_ALIGN_CHK_EN
    ,
    output logic              if_misalign_o
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StFull, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [INST_W-1:0] pend_inst_q, pend_inst_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              out_valid_q, out_valid_d;
`ifdef IF_ALIGN_CHK_EN
    logic              misalign_q, misalign_d;
`endif

    logic ack_live;
    logic ack_drop;
    logic br_take;
    logic loaded;

    // A discarded request keeps its original address on the bus until acked.
    assign imem_req_o  = (state_q == StReq) || discard_q;
    assign imem_addr_o = discard_q ? disc_addr_q : pc_q;
    assign ack_live    = imem_ack_i && (state_q == StReq) && !discard_q;
    assign ack_drop    = imem_ack_i && discard_q;
    assign br_take     = branch_flag_i && !stall_i;

    assign if_pc    = out_pc_q;
    assign if_inst  = out_inst_q;
    assign if_valid = out_valid_q;
`ifdef IF_ALIGN_CHK_EN
    assign if_misalign_o = misalign_q;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        discard_d    = discard_q;
        pend_pc_d    = pend_pc_q;
        pend_inst_d  = pend_inst_q;
        pend_valid_d = pend_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_valid_d  = out_valid_q;
`ifdef IF_ALIGN_CHK_EN
        misalign_d   = misalign_q;
`endif
        loaded       = 1'b0;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (ack_live) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (!out_valid_q || !stall_i) begin
                        out_pc_d    = pc_q;
                        out_inst_d  = imem_rdata_i;
                        out_valid_d = 1'b1;
                        loaded      = 1'b1;
                    end else begin
                        pend_pc_d    = pc_q;
                        pend_inst_d  = imem_rdata_i;
                        pend_valid_d = 1'b1;
                        state_d      = StFull;
                    end
                end
            end
            StFull: begin
                if (!stall_i) begin
                    out_pc_d     = pend_pc_q;
                    out_inst_d   = pend_inst_q;
                    out_valid_d  = 1'b1;
                    loaded       = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = StReq;
                end
            end
            StHalt: begin
            end
        endcase

        if (ack_drop) begin
            discard_d = 1'b0;
        end

        if (!stall_i && !loaded) begin
            out_valid_d = 1'b0;
            out_inst_d  = '0;
        end

        // Redirect overrides any load or consumption decided above.
        if (br_take) begin
            out_valid_d  = 1'b0;
            out_inst_d   = '0;
            out_pc_d     = '0;
            pend_valid_d = 1'b0;
            discard_d    = imem_req_o && !imem_ack_i;
            disc_addr_d  = imem_addr_o;
`ifdef IF_ALIGN_CHK_EN
            pc_d = branch_target_i;
            if (branch_target_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                out_pc_d   = branch_target_i;
                state_d    = StHalt;
            end else begin
                misalign_d = 1'b0;
                state_d    = StReq;
            end
`else
            pc_d    = branch_target_i & ~ADDR_W'(3);
            state_d = StReq;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            disc_addr_q  <= '0;
            discard_q    <= 1'b0;
            pend_pc_q    <= '0;
            pend_inst_q  <= '0;
            pend_valid_q <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            discard_q    <= discard_d;
            pend_pc_q    <= pend_pc_d;
            pend_inst_q  <= pend_inst_d;
            pend_valid_q <= pend_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_valid_q  <= out_valid_d;
`ifdef IF_ALIGN_CHK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

endmodule
